// File: rtl/reset_pkg.sv
// Shared types for the board reset sequencer: FSM states, reset-cause codes, width helper.
package reset_pkg;

    typedef enum logic [1:0] {
        ASSERT  = 2'd0,
        HOLD    = 2'd1,
        RELEASE = 2'd2,
        RUN     = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        CAUSE_POR = 2'd0,
        CAUSE_PLL = 2'd1,
        CAUSE_BTN = 2'd2,
        CAUSE_SW  = 2'd3
    } cause_e;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Reset sources in, sequenced domain resets and status out.
interface reset_sequencer_if #(
    parameter int unsigned NUM_STAGES = 3
);
    import reset_pkg::*;

    logic                  pll_locked;
    logic                  btn_rst_n;
    logic                  sw_rst;
    logic [NUM_STAGES-1:0] rst_n_out;
    logic                  rst_done;
    cause_e                rst_cause;

    modport master (
        output pll_locked, btn_rst_n, sw_rst,
        input  rst_n_out, rst_done, rst_cause
    );

    modport slave (
        input  pll_locked, btn_rst_n, sw_rst,
        output rst_n_out, rst_done, rst_cause
    );

endinterface

// File: rtl/bit_synchronizer.sv
// Multi-flop synchronizer for a single asynchronous bit; clears to 0 on reset.
module bit_synchronizer #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) chain <= '0;
        else        chain <= {chain[STAGES-2:0], d};
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Board reset generator: merges POR, PLL lock, debounced button and soft reset,
// then releases per-domain resets in order after a hold time.
module reset_sequencer
    import reset_pkg::*;
#(
    parameter int unsigned NUM_STAGES      = 3,
    parameter int unsigned HOLD_CYCLES     = 1024,
    parameter int unsigned STAGE_GAP       = 16,
    parameter int unsigned DEBOUNCE_CYCLES = 65536,
    parameter int unsigned SYNC_STAGES     = 2
) (
    input  logic               clk,
    input  logic               asyncrst_n,
    reset_sequencer_if.slave   bus
);

    localparam int unsigned CNT_W = $clog2(max_u(HOLD_CYCLES, STAGE_GAP) + 1);
    localparam int unsigned IDX_W = $clog2(NUM_STAGES + 1);
    localparam int unsigned DB_W  = $clog2(DEBOUNCE_CYCLES);

    logic pll_s;
    logic btn_s;

    bit_synchronizer #(.STAGES(SYNC_STAGES)) u_sync_pll (
        .clk   (clk),
        .rst_n (asyncrst_n),
        .d     (bus.pll_locked),
        .q     (pll_s)
    );

    bit_synchronizer #(.STAGES(SYNC_STAGES)) u_sync_btn (
        .clk   (clk),
        .rst_n (asyncrst_n),
        .d     (bus.btn_rst_n),
        .q     (btn_s)
    );

    // Button debouncer: the debounced level only follows a change that persists.
    logic            btn_db;
    logic [DB_W-1:0] db_cnt;

    always_ff @(posedge clk or negedge asyncrst_n) begin
        if (!asyncrst_n) begin
            btn_db <= 1'b0;
            db_cnt <= '0;
        end else if (btn_s != btn_db) begin
            if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                btn_db <= btn_s;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end else begin
            db_cnt <= '0;
        end
    end

    logic fault_c;
    assign fault_c = !pll_s || !btn_db || bus.sw_rst;

    state_e           state;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] idx;
    // Faults seen before the first release after POR are part of power-up, not a new cause.
    logic             por_pending;

    always_ff @(posedge clk or negedge asyncrst_n) begin
        if (!asyncrst_n) begin
            state         <= ASSERT;
            cnt           <= '0;
            idx           <= '0;
            por_pending   <= 1'b1;
            bus.rst_n_out <= '0;
            bus.rst_done  <= 1'b0;
            bus.rst_cause <= CAUSE_POR;
        end else if (fault_c) begin
            state         <= ASSERT;
            cnt           <= '0;
            idx           <= '0;
            bus.rst_n_out <= '0;
            bus.rst_done  <= 1'b0;
            if (!por_pending) begin
                bus.rst_cause <= !pll_s  ? CAUSE_PLL :
                                 !btn_db ? CAUSE_BTN : CAUSE_SW;
            end
        end else begin
            case (state)
                ASSERT: begin
                    state       <= HOLD;
                    cnt         <= '0;
                    por_pending <= 1'b0;
                end
                HOLD: begin
                    if (cnt == CNT_W'(HOLD_CYCLES - 1)) begin
                        cnt           <= '0;
                        idx           <= '0;
                        bus.rst_n_out <= NUM_STAGES'(1);
                        if (NUM_STAGES == 1) begin
                            state        <= RUN;
                            bus.rst_done <= 1'b1;
                        end else begin
                            state <= RELEASE;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RELEASE: begin
                    if (cnt == CNT_W'(STAGE_GAP - 1)) begin
                        cnt           <= '0;
                        idx           <= idx + IDX_W'(1);
                        bus.rst_n_out <= bus.rst_n_out | (NUM_STAGES'(1) << (idx + IDX_W'(1)));
                        if (idx == IDX_W'(NUM_STAGES - 2)) begin
                            state        <= RUN;
                            bus.rst_done <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RUN: begin
                    bus.rst_n_out <= '1;
                    bus.rst_done  <= 1'b1;
                end
                default: state <= ASSERT;
            endcase
        end
    end

endmodule
